// File: rtl/pdp8_pkg.sv
// -----------------------------------------------------------------------------
// pdp8_pkg
//  Shared types and constants for the PDP-8 instruction fetch unit.
//
//  Contents:
//   ADDR_WIDTH / DATA_WIDTH : 12-bit address and data paths
//   START_ADDR_DEFAULT      : PC value loaded on reset ('o0200)
//   opcode_t                : major opcode field, instruction bits [11:9]
//   ifu_state_t             : fetch sequencer states
//   ifu_instr_t             : one captured and decoded instruction
//   pc_incr()               : sequential PC step, wraps 'o7777 -> 'o0000
// -----------------------------------------------------------------------------
package pdp8_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam addr_t START_ADDR_DEFAULT = 12'o0200;

    // Major opcodes, instruction bits [11:9].
    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_TAD = 3'd1,
        OP_ISZ = 3'd2,
        OP_DCA = 3'd3,
        OP_JMS = 3'd4,
        OP_JMP = 3'd5,
        OP_IOT = 3'd6,
        OP_OPR = 3'd7
    } opcode_t;

    // Fetch sequencer: one pass REQ..HAND per instruction.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_HAND = 3'd4
    } ifu_state_t;

    // Captured instruction as presented to the execute unit.
    typedef struct packed {
        word_t   word;
        addr_t   pc;
        opcode_t opcode;
        logic    ind;
        addr_t   ea;
    } ifu_instr_t;

    // Natural 12-bit overflow gives the 'o7777 -> 'o0000 wrap.
    function automatic addr_t pc_incr(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// ifu_fetch_ctrl_if
//  Bundles the two buses of the fetch unit:
//   - memory fetch port : ifu_rd_req, ifu_rd_addr (out), ifu_rd_data (in)
//   - execute port      : instr_valid/instr_ready handshake, decoded
//                         instruction fields, and the pc_load redirect.
//
//  Modports:
//   master : the fetch unit (drives requests and instructions)
//   slave  : the environment (memory + execute unit)
// -----------------------------------------------------------------------------
interface ifu_fetch_ctrl_if;
    import pdp8_pkg::*;

    // memory fetch port
    logic        ifu_rd_req;
    addr_t       ifu_rd_addr;
    word_t       ifu_rd_data;

    // execute port
    logic        instr_valid;
    logic        instr_ready;
    word_t       instr_word;
    addr_t       instr_pc;
    logic [2:0]  instr_opcode;
    logic        instr_ind;
    addr_t       instr_ea;

    // redirect from execute
    logic        pc_load;
    addr_t       pc_load_addr;

    modport master (
        output ifu_rd_req,
        output ifu_rd_addr,
        input  ifu_rd_data,
        output instr_valid,
        input  instr_ready,
        output instr_word,
        output instr_pc,
        output instr_opcode,
        output instr_ind,
        output instr_ea,
        input  pc_load,
        input  pc_load_addr
    );

    modport slave (
        input  ifu_rd_req,
        input  ifu_rd_addr,
        output ifu_rd_data,
        input  instr_valid,
        output instr_ready,
        input  instr_word,
        input  instr_pc,
        input  instr_opcode,
        input  instr_ind,
        input  instr_ea,
        output pc_load,
        output pc_load_addr
    );

endinterface

// File: rtl/ifu_decode.sv
// -----------------------------------------------------------------------------
// ifu_decode
//  Combinational decode of a PDP-8 instruction word.
//
//  Ports:
//   word_i   in  12  instruction word
//   pc_i     in  12  address the word was fetched from
//   opcode_o out 3   bits [11:9]
//   ind_o    out 1   indirect bit [8]; 0 for IOT/OPR where bit 8 is not
//                    an addressing bit
//   ea_o     out 12  direct operand address: current page when bit 7 (Z)
//                    is set, page zero otherwise
// -----------------------------------------------------------------------------
module ifu_decode
    import pdp8_pkg::*;
(
    input  word_t   word_i,
    input  addr_t   pc_i,
    output opcode_t opcode_o,
    output logic    ind_o,
    output addr_t   ea_o
);

    opcode_t opcode;
    logic    is_mem_ref;

    assign opcode     = opcode_t'(word_i[11:9]);
    // IOT and OPR reuse bits [8:0] as micro-op fields.
    assign is_mem_ref = (opcode != OP_IOT) && (opcode != OP_OPR);

    assign opcode_o = opcode;
    assign ind_o    = is_mem_ref & word_i[8];
    // Page number comes from the fetch address, offset from the word.
    assign ea_o     = word_i[7] ? {pc_i[11:7], word_i[6:0]}
                                : {5'b0_0000, word_i[6:0]};

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// ifu_fetch_ctrl
//  PDP-8 instruction fetch unit. Holds the PC, issues one-cycle read strobes
//  to instruction memory, captures and decodes the returned word, and offers
//  it to the execute unit over a valid/ready handshake. On the handshake the
//  PC either steps by one or takes the execute-supplied redirect address.
//
//  Ports:
//   clk      in  1   clock, all state on posedge
//   reset_n  in  1   asynchronous active-low reset
//   run      in  1   1 = keep fetching; 0 = finish current instruction, park
//   bus      master modport of ifu_fetch_ctrl_if:
//              ifu_rd_req/ifu_rd_addr out, ifu_rd_data in (memory port)
//              instr_valid out, instr_ready in, instr_word/pc/opcode/ind/ea
//              out, pc_load/pc_load_addr in (execute port)
//
//  Sequence per instruction: REQ -> WAIT -> CAPT -> HAND. The strobe is high
//  only in REQ; memory updates ifu_rd_data at the edge that opens WAIT, and
//  the word is registered at the edge leaving CAPT, so instr_valid rises
//  three cycles after the strobe. Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module ifu_fetch_ctrl
    import pdp8_pkg::*;
#(
    parameter addr_t START_ADDR = START_ADDR_DEFAULT
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    ifu_fetch_ctrl_if.master  bus
);

    ifu_state_t state_q;
    addr_t      pc_q;
    addr_t      pc_d;
    logic       rd_req_q;
    addr_t      rd_addr_q;
    logic       valid_q;
    ifu_instr_t instr_q;

    opcode_t    dec_opcode;
    logic       dec_ind;
    addr_t      dec_ea;

    // Decode works on the live memory word and the PC it was fetched from;
    // the result is only registered in CAPT, when the data is settled.
    ifu_decode u_decode (
        .word_i   (bus.ifu_rd_data),
        .pc_i     (pc_q),
        .opcode_o (dec_opcode),
        .ind_o    (dec_ind),
        .ea_o     (dec_ea)
    );

    // PC to use after the current handshake. Only consumed in HAND with
    // instr_ready high, which is what limits pc_load to that one cycle.
    always_comb begin
        pc_d = pc_incr(pc_q);
        if (bus.pc_load) begin
            pc_d = bus.pc_load_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_ADDR;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
        end else begin
            // Strobe defaults low so it can never last more than one cycle.
            rd_req_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q   <= ST_REQ;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= pc_q;
                    end
                end

                ST_REQ: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    state_q <= ST_CAPT;
                end

                ST_CAPT: begin
                    instr_q.word   <= bus.ifu_rd_data;
                    instr_q.pc     <= pc_q;
                    instr_q.opcode <= dec_opcode;
                    instr_q.ind    <= dec_ind;
                    instr_q.ea     <= dec_ea;
                    valid_q        <= 1'b1;
                    state_q        <= ST_HAND;
                end

                ST_HAND: begin
                    // instr_q is left untouched here, so the fields stay
                    // stable for as long as execute stalls.
                    if (bus.instr_ready) begin
                        pc_q    <= pc_d;
                        valid_q <= 1'b0;
                        if (run) begin
                            // Launch the next fetch directly; this is what
                            // gives the 4-cycle back-to-back rate.
                            state_q   <= ST_REQ;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= pc_d;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // rd_addr_q only changes alongside a strobe, so the address holds its
    // last value between fetches.
    assign bus.ifu_rd_req   = rd_req_q;
    assign bus.ifu_rd_addr  = rd_addr_q;
    assign bus.instr_valid  = valid_q;
    assign bus.instr_word   = instr_q.word;
    assign bus.instr_pc     = instr_q.pc;
    assign bus.instr_opcode = instr_q.opcode;
    assign bus.instr_ind    = instr_q.ind;
    assign bus.instr_ea     = instr_q.ea;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch_ctrl
//  Directed bench for ifu_fetch_ctrl with a transaction-level reference
//  model and a per-cycle compare process, plus literal spot checks.
// -----------------------------------------------------------------------------
module tb_ifu_fetch_ctrl;

    localparam int START = 'o0200;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic run = 1'b0;

    ifu_fetch_ctrl_if bus();

    ifu_fetch_ctrl #(.START_ADDR(12'o0200)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- memory model ----------------
    int mem [4096];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = (i * 'o17 + 'o123) % 4096;
        end
        mem['o1234] = 'o1305;
        mem['o1235] = 'o5177;
        mem['o0050] = 'o0305;
        mem['o0051] = 'o7402;
    end

    always @(posedge clk) begin
        if (bus.ifu_rd_req) begin
            bus.ifu_rd_data <= 12'(mem[bus.ifu_rd_addr]);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 'o%0o, want 'o%0o (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endtask

    // Reference decode from the instruction-set rules, by arithmetic.
    function automatic int ref_opcode(input int w);
        return w / 512;
    endfunction

    function automatic int ref_ind(input int w);
        return (ref_opcode(w) >= 6) ? 0 : (w / 256) % 2;
    endfunction

    function automatic int ref_ea(input int w, input int pc);
        int off;
        off = w % 128;
        return ((w / 128) % 2 == 1) ? (pc / 128) * 128 + off : off;
    endfunction

    // ---------------- reference model + compare ----------------
    // m_busy: an instruction is somewhere between strobe and handshake.
    // m_age : cycles since its strobe (0 = strobe cycle).
    int m_pc = START;
    int m_last_addr = 0;
    bit m_busy = 1'b0;
    int m_age = 0;
    bit exp_req;
    bit exp_valid;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_req",    bus.ifu_rd_req,   0);
            chk("rst_addr",   bus.ifu_rd_addr,  0);
            chk("rst_valid",  bus.instr_valid,  0);
            chk("rst_word",   bus.instr_word,   0);
            chk("rst_pc",     bus.instr_pc,     0);
            chk("rst_opcode", bus.instr_opcode, 0);
            chk("rst_ind",    bus.instr_ind,    0);
            chk("rst_ea",     bus.instr_ea,     0);
            m_pc = START;
            m_last_addr = 0;
            m_busy = 1'b0;
            m_age = 0;
        end else begin
            exp_req   = m_busy && (m_age == 0);
            exp_valid = m_busy && (m_age >= 3);
            if (exp_req) m_last_addr = m_pc;
            chk("req",   bus.ifu_rd_req,  int'(exp_req));
            chk("addr",  bus.ifu_rd_addr, m_last_addr);
            chk("valid", bus.instr_valid, int'(exp_valid));
            if (exp_valid) begin
                chk("word",   bus.instr_word,   mem[m_pc]);
                chk("ipc",    bus.instr_pc,     m_pc);
                chk("opcode", bus.instr_opcode, ref_opcode(mem[m_pc]));
                chk("ind",    bus.instr_ind,    ref_ind(mem[m_pc]));
                chk("ea",     bus.instr_ea,     ref_ea(mem[m_pc], m_pc));
            end
            // advance to the next cycle using inputs held across the edge
            if (!m_busy) begin
                if (run) begin
                    m_busy = 1'b1;
                    m_age = 0;
                end
            end else if (exp_valid) begin
                if (bus.instr_ready) begin
                    m_pc = bus.pc_load ? int'(bus.pc_load_addr) : (m_pc + 1) % 4096;
                    if (run) m_age = 0;
                    else     m_busy = 1'b0;
                end
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int a);
        a = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.ifu_rd_req) begin
                a = int'(bus.ifu_rd_addr);
                $display("req  addr='o%04o", a);
                return;
            end
        end
        timeout("wait_req");
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                $display("instr pc='o%04o word='o%04o op=%0d ind=%0d ea='o%04o",
                         bus.instr_pc, bus.instr_word, bus.instr_opcode,
                         bus.instr_ind, bus.instr_ea);
                return;
            end
        end
        timeout("wait_valid");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a;
        int nreq;
        bus.instr_ready  = 1'b0;
        bus.pc_load      = 1'b0;
        bus.pc_load_addr = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run = 1'b1;
        bus.instr_ready = 1'b1;

        // 1: sequential fetch from the reset PC, one-cycle strobe
        wait_req(a); chk("t1_addr0", a, 'o0200);
        @(negedge clk); chk("t1_pulse", bus.ifu_rd_req, 0);
        wait_req(a); chk("t1_addr1", a, 'o0201);
        wait_req(a); chk("t1_addr2", a, 'o0202);

        // 2: decode of TAD at 'o1234, and a page-zero style result
        step(); bus.pc_load = 1'b1; bus.pc_load_addr = 12'o1234;
        wait_req(a); chk("t2_redir", a, 'o1234);
        step(); bus.pc_load = 1'b0;
        wait_valid();
        chk("t2_word", bus.instr_word,   'o1305);
        chk("t2_op",   bus.instr_opcode, 1);
        chk("t2_ind",  bus.instr_ind,    0);
        chk("t2_ea",   bus.instr_ea,     'o1305);
        wait_req(a); chk("t2_next", a, 'o1235);
        step(); bus.pc_load = 1'b1; bus.pc_load_addr = 12'o0050;
        wait_req(a); chk("t2_redir50", a, 'o0050);
        step(); bus.pc_load = 1'b0;
        wait_valid();
        chk("t2_ea_p0", bus.instr_ea, 'o0105);
        chk("t2_op_p0", bus.instr_opcode, 0);

        // 3: execute stall, with pc_load asserted but ignored
        step(); bus.instr_ready = 1'b0;
        wait_valid();
        step(); bus.pc_load = 1'b1; bus.pc_load_addr = 12'o4000;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ifu_rd_req) nreq++;
            chk("t3_valid", bus.instr_valid, 1);
            chk("t3_word",  bus.instr_word,  'o7402);
        end
        chk("t3_noreq", nreq, 0);
        chk("t3_ind",   bus.instr_ind, 0);
        step(); bus.pc_load = 1'b0; bus.instr_ready = 1'b1;
        wait_req(a); chk("t3_next", a, 'o0052);

        // 4 + 5: redirect to 'o4000, then to 'o7777, then wrap
        step(); bus.pc_load = 1'b1; bus.pc_load_addr = 12'o4000;
        wait_req(a); chk("t4_redir", a, 'o4000);
        step(); bus.pc_load_addr = 12'o7777;
        wait_req(a); chk("t5_top", a, 'o7777);
        step(); bus.pc_load = 1'b0;
        wait_req(a); chk("t5_wrap", a, 'o0000);

        // 6: reset during WAIT, then run=0 mid-fetch
        wait_req(a); chk("t6_pre", a, 'o0001);
        step(); reset_n = 1'b0;
        #1;
        chk("t6_req0",   bus.ifu_rd_req,  0);
        chk("t6_addr0",  bus.ifu_rd_addr, 0);
        chk("t6_valid0", bus.instr_valid, 0);
        chk("t6_word0",  bus.instr_word,  0);
        step(); step(); reset_n = 1'b1;
        wait_req(a); chk("t6_restart", a, 'o0200);
        step(); run = 1'b0;
        wait_valid();
        chk("t6_last_pc", bus.instr_pc, 'o0200);
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ifu_rd_req) nreq++;
        end
        chk("t6_parked", nreq, 0);
        chk("t6_novalid", bus.instr_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
